// File: rtl/io_tick_timer_pkg.sv
// -----------------------------------------------------------------------------
// io_tick_timer_pkg
// Shared definitions for the IO tick timer: state encoding, register offsets,
// CTRL bit positions, one-hot IO size codes and the decoder strobe bundle.
// -----------------------------------------------------------------------------
package io_tick_timer_pkg;

  // Timer state encoding; this value is also what STATUS[2:1] reports.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_EXPIRED = 2'd2;

  // Register offsets relative to the block base address.
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_RELOAD = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  // CTRL bit positions.
  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_ONESHOT = 1;
  localparam int CTRL_IRQEN   = 2;
  localparam int CTRL_IRQCLR  = 3;

  // One-hot IO access sizes.
  localparam logic [3:0] SIZE_1B = 4'b0001;
  localparam logic [3:0] SIZE_2B = 4'b0010;
  localparam logic [3:0] SIZE_4B = 4'b0100;
  localparam logic [3:0] SIZE_8B = 4'b1000;

  // Per-register strobes produced by the decoder; only ever set for acked accesses.
  typedef struct packed {
    logic ctrlWr;
    logic reloadWr;
    logic ctrlRd;
    logic reloadRd;
    logic countRd;
    logic statusRd;
  } ioStrobe_t;

  // Byte-lane mask for a one-hot access size; anything else masks everything off.
  function automatic logic [63:0] sizeMask(input logic [3:0] size);
    logic [63:0] mask;
    case (size)
      SIZE_1B: mask = 64'h0000_0000_0000_00FF;
      SIZE_2B: mask = 64'h0000_0000_0000_FFFF;
      SIZE_4B: mask = 64'h0000_0000_FFFF_FFFF;
      SIZE_8B: mask = 64'hFFFF_FFFF_FFFF_FFFF;
      default: mask = 64'h0000_0000_0000_0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/io_tick_timer_dec.sv
// -----------------------------------------------------------------------------
// io_tick_timer_dec
// Combinational IO decode for a four-register window at CAddrBase..+3.
// Ports:
//   AIoAddr    in  16  IO address
//   AIoWrSize  in  4   one-hot write size (0 = no write)
//   AIoRdSize  in  4   one-hot read size  (0 = no read)
//   strobes    out     per-register write/read strobes, gated by ack
//   addrAck    out 1   access in window and every active size legal
//   addrErr    out 1   access in window but some active size illegal
// -----------------------------------------------------------------------------
module io_tick_timer_dec
  import io_tick_timer_pkg::*;
#(
  parameter logic [15:0] CAddrBase = 16'h0000
) (
  input  logic [15:0] AIoAddr,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output ioStrobe_t   strobes,
  output logic        addrAck,
  output logic        addrErr
);

  logic [16:0] offsetWide_s;
  logic [1:0]  offset_s;
  logic        inRange_s;
  logic        wrActive_s;
  logic        rdActive_s;
  logic        wrLegal_s;
  logic        rdLegal_s;
  logic        anyAccess_s;
  logic        accessOk_s;

  // Window match and per-offset size legality; a 17-bit difference makes
  // addresses below the base look huge, so one compare covers both ends.
  always_comb begin
    offsetWide_s = {1'b0, AIoAddr} - {1'b0, CAddrBase};
    inRange_s    = (offsetWide_s < 17'd4);
    offset_s     = offsetWide_s[1:0];
    wrActive_s   = (AIoWrSize != 4'b0000);
    rdActive_s   = (AIoRdSize != 4'b0000);
    wrLegal_s    = 1'b0;
    rdLegal_s    = 1'b0;
    case (offset_s)
      OFF_CTRL: begin
        wrLegal_s = (AIoWrSize == SIZE_1B);
        rdLegal_s = (AIoRdSize == SIZE_1B);
      end
      OFF_RELOAD: begin
        wrLegal_s = (AIoWrSize == SIZE_2B) || (AIoWrSize == SIZE_4B);
        rdLegal_s = (AIoRdSize == SIZE_2B) || (AIoRdSize == SIZE_4B);
      end
      OFF_COUNT: begin
        wrLegal_s = 1'b0;
        rdLegal_s = (AIoRdSize == SIZE_2B) || (AIoRdSize == SIZE_4B);
      end
      OFF_STATUS: begin
        wrLegal_s = 1'b0;
        rdLegal_s = (AIoRdSize == SIZE_1B);
      end
      default: begin
        wrLegal_s = 1'b0;
        rdLegal_s = 1'b0;
      end
    endcase
    anyAccess_s = inRange_s & (wrActive_s | rdActive_s);
    accessOk_s  = (~wrActive_s | wrLegal_s) & (~rdActive_s | rdLegal_s);
  end

  // Ack/Err and strobes; strobes only fire for a fully legal access.
  always_comb begin
    addrAck          = anyAccess_s & accessOk_s;
    addrErr          = anyAccess_s & ~accessOk_s;
    strobes.ctrlWr   = addrAck & wrActive_s & (offset_s == OFF_CTRL);
    strobes.reloadWr = addrAck & wrActive_s & (offset_s == OFF_RELOAD);
    strobes.ctrlRd   = addrAck & rdActive_s & (offset_s == OFF_CTRL);
    strobes.reloadRd = addrAck & rdActive_s & (offset_s == OFF_RELOAD);
    strobes.countRd  = addrAck & rdActive_s & (offset_s == OFF_COUNT);
    strobes.statusRd = addrAck & rdActive_s & (offset_s == OFF_STATUS);
  end

endmodule

// File: rtl/io_tick_timer.sv
// -----------------------------------------------------------------------------
// io_tick_timer
// Programmable down-counting event timer driven by an upstream cascade tick.
// Counts RELOAD+1 input ticks per period, emits a one-cycle ATickO and sets a
// sticky interrupt flag on each expiry. Optional one-shot mode.
// Ports:
//   AClkH       in  1   clock
//   AResetH     in  1   synchronous active-high reset
//   AClkHEn     in  1   clock enable; 0 freezes all state and outputs
//   AIoAddr     in  16  IO address
//   AIoMosi     in  64  IO write data
//   AIoWrSize   in  4   one-hot write size
//   AIoRdSize   in  4   one-hot read size
//   AIoMiso     out 64  registered read data (0 when no acked read)
//   AIoAddrAck  out 1   combinational ack
//   AIoAddrErr  out 1   combinational size error
//   ATickI      in  1   upstream tick
//   ATickO      out 1   registered expiry tick
//   AIrq        out 1   IrqFlag & IrqEn
// -----------------------------------------------------------------------------
module io_tick_timer
  import io_tick_timer_pkg::*;
#(
  parameter logic [15:0]      CAddrBase  = 16'h0000,
  parameter int               CCntW      = 16,
  parameter logic [CCntW-1:0] CReloadRst = 16'hFFFF
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [63:0] AIoMosi,
  input  logic [3:0]  AIoWrSize,
  input  logic [3:0]  AIoRdSize,
  output logic [63:0] AIoMiso,
  output logic        AIoAddrAck,
  output logic        AIoAddrErr,
  input  logic        ATickI,
  output logic        ATickO,
  output logic        AIrq
);

  ioStrobe_t        strobes_s;
  logic [1:0]       state_r;
  logic [1:0]       stateNext_s;
  logic [CCntW-1:0] count_r;
  logic [CCntW-1:0] countNext_s;
  logic [CCntW-1:0] reload_r;
  logic [CCntW-1:0] reloadNext_s;
  logic             enable_r;
  logic             oneShot_r;
  logic             irqEn_r;
  logic             irqFlag_r;
  logic             irqFlagNext_s;
  logic             tickO_r;
  logic [63:0]      miso_r;
  logic [63:0]      wrData_s;
  logic [63:0]      rdRaw_s;
  logic [63:0]      rdData_s;
  logic             restart_s;
  logic             expire_s;
  logic             unusedWrBits_s;

  io_tick_timer_dec #(
    .CAddrBase (CAddrBase)
  ) uDec (
    .AIoAddr   (AIoAddr),
    .AIoWrSize (AIoWrSize),
    .AIoRdSize (AIoRdSize),
    .strobes   (strobes_s),
    .addrAck   (AIoAddrAck),
    .addrErr   (AIoAddrErr)
  );

  // Write data trimmed to the access size; upper bits beyond the counter are dropped.
  always_comb begin
    wrData_s       = AIoMosi & sizeMask(AIoWrSize);
    unusedWrBits_s = ^wrData_s[63:CCntW];
    // A same-cycle RELOAD write is visible to a reload happening on this edge.
    if (strobes_s.reloadWr) begin
      reloadNext_s = wrData_s[CCntW-1:0];
    end else begin
      reloadNext_s = reload_r;
    end
  end

  // Expiry detect and next state/count. A CTRL write always wins over the
  // tick for state; an Enable=1 write also swallows any tick this cycle.
  always_comb begin
    restart_s   = strobes_s.ctrlWr & AIoMosi[CTRL_ENABLE];
    expire_s    = (state_r == ST_RUN) & ATickI &
                  (count_r == {CCntW{1'b0}}) & ~restart_s;
    stateNext_s = state_r;
    countNext_s = count_r;
    if (strobes_s.ctrlWr) begin
      if (AIoMosi[CTRL_ENABLE]) begin
        stateNext_s = ST_RUN;
        countNext_s = reloadNext_s;
      end else begin
        // Disable parks the counter where it is.
        stateNext_s = ST_IDLE;
      end
    end else if ((state_r == ST_RUN) && ATickI) begin
      if (count_r == {CCntW{1'b0}}) begin
        if (oneShot_r) begin
          stateNext_s = ST_EXPIRED;
          countNext_s = {CCntW{1'b0}};
        end else begin
          countNext_s = reloadNext_s;
        end
      end else begin
        countNext_s = count_r - {{(CCntW-1){1'b0}}, 1'b1};
      end
    end else begin
      stateNext_s = state_r;
      countNext_s = count_r;
    end
  end

  // Sticky interrupt flag: an expiry beats a simultaneous IrqClr.
  always_comb begin
    if (expire_s) begin
      irqFlagNext_s = 1'b1;
    end else if (strobes_s.ctrlWr && AIoMosi[CTRL_IRQCLR]) begin
      irqFlagNext_s = 1'b0;
    end else begin
      irqFlagNext_s = irqFlag_r;
    end
  end

  // Read mux, zero-extended then trimmed to the read size.
  always_comb begin
    if (strobes_s.ctrlRd) begin
      rdRaw_s = {60'h0, 1'b0, irqEn_r, oneShot_r, enable_r};
    end else if (strobes_s.reloadRd) begin
      rdRaw_s = {{(64-CCntW){1'b0}}, reload_r};
    end else if (strobes_s.countRd) begin
      rdRaw_s = {{(64-CCntW){1'b0}}, count_r};
    end else if (strobes_s.statusRd) begin
      rdRaw_s = {61'h0, state_r, irqFlag_r};
    end else begin
      rdRaw_s = 64'h0;
    end
    rdData_s = rdRaw_s & sizeMask(AIoRdSize);
  end

  // All timer and bus state; the enable freezes everything including outputs.
  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state_r   <= ST_IDLE;
      count_r   <= {CCntW{1'b0}};
      reload_r  <= CReloadRst;
      enable_r  <= 1'b0;
      oneShot_r <= 1'b0;
      irqEn_r   <= 1'b0;
      irqFlag_r <= 1'b0;
      tickO_r   <= 1'b0;
      miso_r    <= 64'h0;
    end else if (AClkHEn) begin
      state_r   <= stateNext_s;
      count_r   <= countNext_s;
      reload_r  <= reloadNext_s;
      irqFlag_r <= irqFlagNext_s;
      tickO_r   <= expire_s;
      miso_r    <= rdData_s;
      if (strobes_s.ctrlWr) begin
        enable_r  <= AIoMosi[CTRL_ENABLE];
        oneShot_r <= AIoMosi[CTRL_ONESHOT];
        irqEn_r   <= AIoMosi[CTRL_IRQEN];
      end
    end
  end

  assign AIoMiso = miso_r;
  assign ATickO  = tickO_r;
  assign AIrq    = irqFlag_r & irqEn_r;

endmodule

// File: tb/tb_io_tick_timer.sv
module tb_io_tick_timer;

  localparam logic [15:0] BASE = 16'h0040;

  logic        AClkH = 1'b0;
  logic        AResetH = 1'b1;
  logic        AClkHEn = 1'b1;
  logic [15:0] AIoAddr = 16'h0;
  logic [63:0] AIoMosi = 64'h0;
  logic [3:0]  AIoWrSize = 4'h0;
  logic [3:0]  AIoRdSize = 4'h0;
  logic [63:0] AIoMiso;
  logic        AIoAddrAck;
  logic        AIoAddrErr;
  logic        ATickI = 1'b0;
  logic        ATickO;
  logic        AIrq;

  int checks = 0;
  int errors = 0;
  logic checking = 1'b0;

  io_tick_timer #(.CAddrBase(BASE), .CCntW(16), .CReloadRst(16'hFFFF)) dut (
    .AClkH(AClkH), .AResetH(AResetH), .AClkHEn(AClkHEn),
    .AIoAddr(AIoAddr), .AIoMosi(AIoMosi), .AIoWrSize(AIoWrSize), .AIoRdSize(AIoRdSize),
    .AIoMiso(AIoMiso), .AIoAddrAck(AIoAddrAck), .AIoAddrErr(AIoAddrErr),
    .ATickI(ATickI), .ATickO(ATickO), .AIrq(AIrq)
  );

  always #5 AClkH = ~AClkH;

  // ---------------- reference model ----------------
  // Timer is described as "period loaded" and "ticks consumed since load";
  // the visible COUNT is period - taken, and a tick arriving when nothing is
  // left is an expiry.
  typedef struct packed {
    logic [1:0]  mode;     // 0 idle, 1 run, 2 expired (STATUS encoding)
    logic [15:0] period;
    logic [15:0] taken;
    logic [15:0] reload;
    logic        en;
    logic        os;
    logic        ie;
    logic        flag;
    logic        tick;
    logic [63:0] miso;
  } mdl_t;

  localparam logic [3:0] WR_SET [4] = '{4'b0001, 4'b0110, 4'b0000, 4'b0000};
  localparam logic [3:0] RD_SET [4] = '{4'b0001, 4'b0110, 4'b0110, 4'b0001};

  mdl_t mdl;

  function automatic logic [63:0] bytesMask(input logic [3:0] size);
    int n;
    n = (size == 4'b0001) ? 1 : (size == 4'b0010) ? 2 : (size == 4'b0100) ? 4 :
        (size == 4'b1000) ? 8 : 0;
    if (n == 8) return 64'hFFFF_FFFF_FFFF_FFFF;
    return (64'd1 << (8 * n)) - 64'd1;
  endfunction

  // Returns {ack, err}.
  function automatic logic [1:0] busResp(input logic [15:0] addr, input logic [3:0] wr,
                                         input logic [3:0] rd);
    int off;
    logic wrOk, rdOk;
    off = int'(addr) - int'(BASE);
    if (off < 0 || off > 3 || (wr == 4'd0 && rd == 4'd0)) return 2'b00;
    wrOk = (wr == 4'd0) || ($onehot(wr) && ((wr & WR_SET[off]) != 4'd0));
    rdOk = (rd == 4'd0) || ($onehot(rd) && ((rd & RD_SET[off]) != 4'd0));
    return (wrOk && rdOk) ? 2'b10 : 2'b01;
  endfunction

  function automatic mdl_t step(input mdl_t m, input logic rst, input logic en,
                                input logic [15:0] addr, input logic [63:0] mosi,
                                input logic [3:0] wr, input logic [3:0] rd, input logic tick);
    mdl_t n;
    logic [1:0] resp;
    int off;
    logic wrCtrl, wrRel, doRd, restart, expire;
    logic [15:0] cnt, newRel;
    logic [63:0] wdata, rv;
    n = m;
    if (rst) begin
      n = '0;
      n.reload = 16'hFFFF;
      return n;
    end
    if (!en) return m;
    resp   = busResp(addr, wr, rd);
    off    = int'(addr) - int'(BASE);
    wrCtrl = resp[1] && wr != 4'd0 && off == 0;
    wrRel  = resp[1] && wr != 4'd0 && off == 1;
    doRd   = resp[1] && rd != 4'd0;
    cnt    = m.period - m.taken;
    wdata  = mosi & bytesMask(wr);
    rv = 64'h0;
    if (doRd) begin
      case (off)
        0: rv = {61'h0, m.ie, m.os, m.en};
        1: rv = {48'h0, m.reload};
        2: rv = {48'h0, cnt};
        3: rv = {61'h0, m.mode, m.flag};
        default: rv = 64'h0;
      endcase
    end
    n.miso = rv & bytesMask(rd);
    newRel = wrRel ? wdata[15:0] : m.reload;
    n.reload = newRel;
    restart = wrCtrl && mosi[0];
    expire = (m.mode == 2'd1) && tick && (cnt == 16'd0) && !restart;
    n.tick = expire;
    if (wrCtrl) begin
      n.en = mosi[0]; n.os = mosi[1]; n.ie = mosi[2];
      if (mosi[0]) begin n.mode = 2'd1; n.period = newRel; n.taken = 16'd0; end
      else n.mode = 2'd0;
    end else if (m.mode == 2'd1 && tick) begin
      if (expire) begin
        if (m.os) begin n.mode = 2'd2; n.period = 16'd0; n.taken = 16'd0; end
        else begin n.period = newRel; n.taken = 16'd0; end
      end else n.taken = m.taken + 16'd1;
    end
    if (expire) n.flag = 1'b1;
    else if (wrCtrl && mosi[3]) n.flag = 1'b0;
    return n;
  endfunction

  always @(posedge AClkH)
    mdl <= step(mdl, AResetH, AClkHEn, AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ATickI);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge AClkH) begin
    if (checking) begin
      logic [1:0] r;
      r = busResp(AIoAddr, AIoWrSize, AIoRdSize);
      chk("ATickO", {63'h0, ATickO}, {63'h0, mdl.tick});
      chk("AIrq", {63'h0, AIrq}, {63'h0, mdl.flag & mdl.ie});
      chk("AIoMiso", AIoMiso, mdl.miso);
      chk("AIoAddrAck", {63'h0, AIoAddrAck}, {63'h0, r[1]});
      chk("AIoAddrErr", {63'h0, AIoAddrErr}, {63'h0, r[0]});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge AClkH); #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [3:0] size, input logic [63:0] data);
    AIoAddr = BASE + {14'h0, off}; AIoWrSize = size; AIoMosi = data;
    cyc();
    AIoWrSize = 4'h0; AIoMosi = 64'h0;
  endtask

  task automatic rd(input logic [15:0] addr, input logic [3:0] size, output logic [63:0] data);
    AIoAddr = addr; AIoRdSize = size;
    cyc();
    AIoRdSize = 4'h0;
    data = AIoMiso;
  endtask

  logic [63:0] d;
  logic [31:0] pulseMask;
  int tickNo, irqTick, pulses;
  logic [3:0] sizes [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b0000};

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    cyc();
    checking = 1'b1;
    cyc();
    AResetH = 1'b0;
    rd(BASE + 16'd0, 4'b0001, d); chk("rst CTRL", d, 64'h00);
    rd(BASE + 16'd1, 4'b0010, d); chk("rst RELOAD", d, 64'hFFFF);
    rd(BASE + 16'd2, 4'b0010, d); chk("rst COUNT", d, 64'h0000);
    rd(BASE + 16'd3, 4'b0001, d); chk("rst STATUS", d, 64'h00);
    chk("rst ATickO", {63'h0, ATickO}, 64'h0);
    chk("rst AIrq", {63'h0, AIrq}, 64'h0);

    // Periodic: RELOAD=3, every 4th cycle a tick, 12 ticks
    wr(2'd1, 4'b0010, 64'd3);
    wr(2'd0, 4'b0001, 64'h05);
    tickNo = 0; irqTick = 0; pulseMask = 32'h0;
    for (int i = 1; i <= 48; i++) begin
      ATickI = (i % 4 == 0);
      if (ATickI) tickNo++;
      cyc();
      ATickI = 1'b0;
      if (ATickO) pulseMask[tickNo] = 1'b1;
      if (AIrq && irqTick == 0) irqTick = tickNo;
    end
    chk("periodic pulse ticks", {32'h0, pulseMask}, 64'h1110);
    chk("periodic irq tick", 64'(irqTick), 64'd4);
    wr(2'd0, 4'b0001, 64'h0D);
    chk("irqclr AIrq", {63'h0, AIrq}, 64'h0);
    rd(BASE + 16'd3, 4'b0001, d); chk("irqclr STATUS", d, 64'h02);

    // One-shot: RELOAD=2
    wr(2'd1, 4'b0010, 64'd2);
    wr(2'd0, 4'b0001, 64'h03);
    tickNo = 0; pulseMask = 32'h0;
    for (int i = 1; i <= 26; i++) begin
      ATickI = (i % 2 == 0);
      if (ATickI) tickNo++;
      cyc();
      ATickI = 1'b0;
      if (ATickO) pulseMask[tickNo] = 1'b1;
    end
    chk("oneshot pulse ticks", {32'h0, pulseMask}, 64'h8);
    rd(BASE + 16'd3, 4'b0001, d); chk("oneshot STATUS", d, 64'h05);
    rd(BASE + 16'd2, 4'b0100, d); chk("oneshot COUNT", d, 64'h0);

    // RELOAD=0, continuous ticks
    wr(2'd1, 4'b0010, 64'd0);
    wr(2'd0, 4'b0001, 64'h01);
    pulses = 0;
    ATickI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (ATickO) pulses++;
    end
    chk("reload0 pulses", 64'(pulses), 64'd8);
    AIoAddr = BASE; AIoMosi = 64'h0; AIoWrSize = 4'b0001;
    cyc();
    AIoWrSize = 4'h0; ATickI = 1'b0;
    chk("disable+expiry ATickO", {63'h0, ATickO}, 64'h1);
    rd(BASE + 16'd3, 4'b0001, d); chk("disable STATUS", d, 64'h01);

    // IO errors
    AIoAddr = BASE + 16'd1; AIoMosi = 64'h1234; AIoWrSize = 4'b0001; #1;
    chk("1B reload Err", {63'h0, AIoAddrErr}, 64'h1);
    chk("1B reload Ack", {63'h0, AIoAddrAck}, 64'h0);
    cyc(); AIoWrSize = 4'h0;
    rd(BASE + 16'd1, 4'b0010, d); chk("reload unchanged", d, 64'h0);
    AIoAddr = BASE + 16'd2; AIoWrSize = 4'b0010; #1;
    chk("2B count wr Err", {63'h0, AIoAddrErr}, 64'h1);
    cyc(); AIoWrSize = 4'h0;
    AIoAddr = BASE + 16'd4; AIoRdSize = 4'b0010; #1;
    chk("out-of-range Ack", {63'h0, AIoAddrAck}, 64'h0);
    chk("out-of-range Err", {63'h0, AIoAddrErr}, 64'h0);
    AIoAddr = BASE - 16'd1; #1;
    chk("below-base Err", {63'h0, AIoAddrErr}, 64'h0);
    cyc(); AIoRdSize = 4'h0;

    // Reset mid-count, then clock-enable freeze
    wr(2'd1, 4'b0010, 64'd5);
    wr(2'd0, 4'b0001, 64'h01);
    rd(BASE + 16'd2, 4'b0010, d); chk("count loaded", d, 64'd5);
    AResetH = 1'b1; cyc(); AResetH = 1'b0;
    chk("mid reset ATickO", {63'h0, ATickO}, 64'h0);
    rd(BASE + 16'd2, 4'b0010, d); chk("mid reset COUNT", d, 64'h0);
    rd(BASE + 16'd3, 4'b0001, d); chk("mid reset STATUS", d, 64'h0);
    wr(2'd1, 4'b0010, 64'd5);
    wr(2'd0, 4'b0001, 64'h01);
    ATickI = 1'b1; cyc(); cyc(); ATickI = 1'b0;
    AClkHEn = 1'b0; ATickI = 1'b1;
    for (int i = 0; i < 5; i++) cyc();
    ATickI = 1'b0; AClkHEn = 1'b1;
    rd(BASE + 16'd2, 4'b0010, d); chk("gated COUNT", d, 64'd3);

    // Randomized traffic, checked every cycle by the model
    for (int i = 0; i < 4000; i++) begin
      int op;
      logic [15:0] a;
      AClkHEn = ($urandom % 10) != 0;
      AResetH = AClkHEn && (($urandom % 500) == 0);
      ATickI = ($urandom % 3) == 0;
      op = $urandom % 4;
      a = BASE - 16'd1 + 16'($urandom % 6);
      AIoAddr = a;
      AIoWrSize = 4'h0; AIoRdSize = 4'h0;
      AIoMosi = {$urandom, $urandom};
      if (a == BASE + 16'd1) AIoMosi = 64'($urandom % 5);
      if (a == BASE) AIoMosi[0] = ($urandom % 4) != 0;
      if (op == 1) AIoWrSize = sizes[$urandom % 6];
      else if (op == 2) AIoRdSize = sizes[$urandom % 6];
      cyc();
    end
    AResetH = 1'b0; AClkHEn = 1'b1; ATickI = 1'b0;
    AIoWrSize = 4'h0; AIoRdSize = 4'h0;
    cyc(); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
